// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter and sequencer for the shared 32-bit memory bus.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   m0_* / m1_*           per-master request (req, rw, addr, wdata) and response
//                         (rdata, one-cycle ack, err qualifying ack = timed out)
//   bus_address/rw/wdata  transaction driven to memory while in BUS, zero otherwise
//   bus_data_oe           drive enable for bus_wdata (latched rw while in BUS)
//   bus_rdata, bus_ready  read data and access-complete strobe from memory
//
// Parameter TIMEOUT bounds the BUS wait in cycles; 0 disables the timeout.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_rw,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_rw,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] bus_address,
  output logic        bus_rw,
  output logic [31:0] bus_wdata,
  output logic        bus_data_oe,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;  // doubles as last_grant for round-robin
  logic              rw_q, rw_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [31:0]       m0_rdata_q, m0_rdata_d;
  logic [31:0]       m1_rdata_q, m1_rdata_d;
  logic              sel;
  logic              timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT));

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    // Tie goes to the master not granted last; a lone requester always wins.
    sel        = (m0_req && m1_req) ? ~grant_q : m1_req;

    case (state_q)
      StIdle: begin
        if (m0_req || m1_req) begin
          grant_d = sel;
          rw_d    = sel ? m1_rw    : m0_rw;
          addr_d  = sel ? m1_addr  : m0_addr;
          wdata_d = sel ? m1_wdata : m0_wdata;
          cnt_d   = '0;
          state_d = StBus;
        end
      end
      StBus: begin
        // bus_ready takes priority over a timeout expiring in the same cycle.
        if (bus_ready) begin
          state_d = StDone;
          err_d   = 1'b0;
          if (!rw_q) begin
            if (grant_q) m1_rdata_d = bus_rdata;
            else         m0_rdata_d = bus_rdata;
          end
        end else if (timeout_hit) begin
          state_d = StDone;
          err_d   = 1'b1;
          if (!rw_q) begin
            if (grant_q) m1_rdata_d = '0;
            else         m0_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      grant_q    <= 1'b1;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  // Outputs decode from registered state only, so reset clears them asynchronously.
  always_comb begin
    bus_address = '0;
    bus_rw      = 1'b0;
    bus_wdata   = '0;
    bus_data_oe = 1'b0;
    if (state_q == StBus) begin
      bus_address = addr_q;
      bus_rw      = rw_q;
      bus_wdata   = wdata_q;
      bus_data_oe = rw_q;
    end
    m0_ack   = (state_q == StDone) && !grant_q;
    m1_ack   = (state_q == StDone) &&  grant_q;
    m0_err   = m0_ack && err_q;
    m1_err   = m1_ack && err_q;
    m0_rdata = m0_rdata_q;
    m1_rdata = m1_rdata_q;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_rw, m1_req, m1_rw;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] bus_address, bus_wdata, bus_rdata;
  logic        bus_rw, bus_data_oe, bus_ready;

  typedef struct {
    logic        m;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_rd[2];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .m0_req     (m0_req),
    .m0_rw      (m0_rw),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_rdata   (m0_rdata),
    .m0_ack     (m0_ack),
    .m0_err     (m0_err),
    .m1_req     (m1_req),
    .m1_rw      (m1_rw),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_rdata   (m1_rdata),
    .m1_ack     (m1_ack),
    .m1_err     (m1_err),
    .bus_address(bus_address),
    .bus_rw     (bus_rw),
    .bus_wdata  (bus_wdata),
    .bus_data_oe(bus_data_oe),
    .bus_rdata  (bus_rdata),
    .bus_ready  (bus_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic m, input logic err, input logic [31:0] rdata);
    exp_t e;
    e.m     = m;
    e.err   = err;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  // Scoreboard consumer: every ack pops one expected completion.
  always @(negedge clk) begin
    if (m0_ack || m1_ack) begin
      check("ack_exclusive", 32'(m0_ack && m1_ack), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(m1_ack), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_master", 32'(m1_ack), 32'(e.m));
        check("sb_err", 32'(e.m ? m1_err : m0_err), 32'(e.err));
        check("sb_rdata", e.m ? m1_rdata : m0_rdata, e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required end within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    m0_req = 0; m0_rw = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_rw = 0; m1_addr = '0; m1_wdata = '0;
    bus_rdata = '0; bus_ready = 0;
    model_rd[0] = '0; model_rd[1] = '0;
    #2;
    check("rst_m0_ack", 32'(m0_ack), 32'd0);
    check("rst_m1_ack", 32'(m1_ack), 32'd0);
    check("rst_m0_err", 32'(m0_err), 32'd0);
    check("rst_m0_rdata", m0_rdata, 32'd0);
    check("rst_m1_rdata", m1_rdata, 32'd0);
    check("rst_bus_addr", bus_address, 32'd0);
    check("rst_bus_oe", 32'(bus_data_oe), 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Zero-wait read by m0
    m0_req = 1; m0_rw = 0; m0_addr = 32'h100;
    bus_ready = 1; bus_rdata = 32'hDEAD_BEEF;
    model_rd[0] = 32'hDEAD_BEEF;
    push(1'b0, 1'b0, model_rd[0]);
    @(negedge clk);
    check("t1_addr", bus_address, 32'h100);
    check("t1_oe", 32'(bus_data_oe), 32'd0);
    check("t1_ack_early", 32'(m0_ack), 32'd0);
    @(negedge clk);
    check("t1_ack", 32'(m0_ack), 32'd1);
    check("t1_err", 32'(m0_err), 32'd0);
    check("t1_rdata", m0_rdata, 32'hDEAD_BEEF);
    m0_req = 0; bus_ready = 0;
    @(negedge clk);

    // m1 write with 3 wait states
    m1_req = 1; m1_rw = 1; m1_addr = 32'h2000; m1_wdata = 32'h55AA;
    push(1'b1, 1'b0, model_rd[1]);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("t2_oe", 32'(bus_data_oe), 32'd1);
      check("t2_rw", 32'(bus_rw), 32'd1);
      check("t2_wdata", bus_wdata, 32'h55AA);
      check("t2_addr", bus_address, 32'h2000);
      check("t2_ack_early", 32'(m1_ack), 32'd0);
      if (i == 3) bus_ready = 1;
      @(negedge clk);
    end
    check("t2_m1_ack", 32'(m1_ack), 32'd1);
    check("t2_m0_ack", 32'(m0_ack), 32'd0);
    check("t2_oe_done", 32'(bus_data_oe), 32'd0);
    m1_req = 0; bus_ready = 0;
    @(negedge clk);
    check("t2_oe_idle", 32'(bus_data_oe), 32'd0);

    // Contention from reset: grants alternate m0, m1, m0, m1
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_rd[0] = '0; model_rd[1] = '0;
    m0_req = 1; m0_rw = 0; m0_addr = 32'h3000;
    m1_req = 1; m1_rw = 0; m1_addr = 32'h3100;
    bus_ready = 1;
    for (int j = 0; j < 4; j++) begin
      model_rd[j % 2] = 32'hA000_0000 + 32'(1 + 3 * j);
      push(1'(j % 2), 1'b0, model_rd[j % 2]);
    end
    for (int c = 0; c < 12; c++) begin
      bus_rdata = 32'hA000_0000 + 32'(c);
      if (c % 3 == 1) begin
        check("t3_addr", bus_address, ((c / 3) % 2 == 1) ? 32'h3100 : 32'h3000);
      end
      if (c % 3 == 2) begin
        check("t3_m0_ack", 32'(m0_ack), 32'(((c / 3) % 2) == 0));
        check("t3_m1_ack", 32'(m1_ack), 32'(((c / 3) % 2) == 1));
      end else begin
        check("t3_no_ack", 32'(m0_ack || m1_ack), 32'd0);
      end
      if (c == 11) begin
        m0_req = 0; m1_req = 0;
      end
      @(negedge clk);
    end
    bus_ready = 0;
    @(negedge clk);

    // Timeout: TIMEOUT=4, bus_ready never arrives
    m0_req = 1; m0_rw = 0; m0_addr = 32'h4000;
    model_rd[0] = '0;
    push(1'b0, 1'b1, 32'd0);
    @(negedge clk);
    for (int c = 1; c <= 5; c++) begin
      check("t4_addr", bus_address, 32'h4000);
      check("t4_no_ack", 32'(m0_ack), 32'd0);
      @(negedge clk);
    end
    check("t4_ack", 32'(m0_ack), 32'd1);
    check("t4_err", 32'(m0_err), 32'd1);
    check("t4_rdata", m0_rdata, 32'd0);
    m0_req = 0;
    @(negedge clk);

    // Timeout tie: bus_ready on the expiry cycle wins
    m1_req = 1; m1_rw = 0; m1_addr = 32'h5000;
    model_rd[1] = 32'h1234_5678;
    push(1'b1, 1'b0, model_rd[1]);
    @(negedge clk);
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) begin
        bus_ready = 1; bus_rdata = 32'h1234_5678;
      end
      check("t5_no_ack", 32'(m1_ack), 32'd0);
      @(negedge clk);
    end
    check("t5_ack", 32'(m1_ack), 32'd1);
    check("t5_err", 32'(m1_err), 32'd0);
    check("t5_rdata", m1_rdata, 32'h1234_5678);
    m1_req = 0; bus_ready = 0;
    @(negedge clk);

    // Reset during BUS of a write: drive drops at once, no ack
    m1_req = 1; m1_rw = 1; m1_addr = 32'h6000; m1_wdata = 32'hCAFE;
    @(negedge clk);
    check("t6_oe_bus", 32'(bus_data_oe), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_oe_rst", 32'(bus_data_oe), 32'd0);
    check("t6_addr_rst", bus_address, 32'd0);
    check("t6_rw_rst", 32'(bus_rw), 32'd0);
    check("t6_no_ack", 32'(m1_ack), 32'd0);
    m1_req = 0;
    @(negedge clk);
    check("t6_no_ack2", 32'(m0_ack || m1_ack), 32'd0);
    reset = 1'b1;
    model_rd[0] = '0; model_rd[1] = '0;
    m0_req = 1; m0_rw = 0; m0_addr = 32'h7000;
    m1_req = 1; m1_rw = 0; m1_addr = 32'h7100;
    bus_ready = 1; bus_rdata = 32'h0BAD_F00D;
    model_rd[0] = 32'h0BAD_F00D;
    push(1'b0, 1'b0, model_rd[0]);
    @(negedge clk);
    check("t6_tie_addr", bus_address, 32'h7000);
    @(negedge clk);
    check("t6_tie_m0_ack", 32'(m0_ack), 32'd1);
    check("t6_tie_m1_ack", 32'(m1_ack), 32'd0);
    m0_req = 0; m1_req = 0; bus_ready = 0;
    @(negedge clk);
    @(negedge clk);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
